// File: rtl/dct_transpose_buf.sv
`default_nettype none
// ============================================================================
//  Module      : dct_transpose_buf
//  Description : Ping-pong 8x8 transpose buffer between the row and column
//                1-D DCT stages. Row vectors are written into one bank while
//                the other bank is read out column by column.
//
//  Ports       : i_clk              clock, all state on rising edge
//                i_rst_n            asynchronous active-low reset
//                i_valid            row vector present (producer never stalls)
//                i_data0..i_data7   row coefficients, index = column position
//                i_ready            downstream accepts o_data this cycle
//                o_valid            column vector valid
//                o_data0..o_data7   column coefficients, index = row position
//                o_col              column index of current output
//                o_last             high with column 7 of a block
//                o_overflow         sticky, a row was dropped
//
//  Revision    : 1.0  initial release
// ============================================================================
module dct_transpose_buf #(
    parameter int DATA_W = 14
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data0,
    input  logic signed [DATA_W-1:0] i_data1,
    input  logic signed [DATA_W-1:0] i_data2,
    input  logic signed [DATA_W-1:0] i_data3,
    input  logic signed [DATA_W-1:0] i_data4,
    input  logic signed [DATA_W-1:0] i_data5,
    input  logic signed [DATA_W-1:0] i_data6,
    input  logic signed [DATA_W-1:0] i_data7,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data0,
    output logic signed [DATA_W-1:0] o_data1,
    output logic signed [DATA_W-1:0] o_data2,
    output logic signed [DATA_W-1:0] o_data3,
    output logic signed [DATA_W-1:0] o_data4,
    output logic signed [DATA_W-1:0] o_data5,
    output logic signed [DATA_W-1:0] o_data6,
    output logic signed [DATA_W-1:0] o_data7,
    output logic [2:0]               o_col,
    output logic                     o_last,
    output logic                     o_overflow
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    rd_state_t r_state;
    rd_state_t w_state_nxt;

    // Bank storage: [bank][row][col]; contents are deliberately not reset.
    logic signed [DATA_W-1:0] r_mem [2][8][8];
    logic signed [DATA_W-1:0] w_in  [8];
    logic signed [DATA_W-1:0] r_out [8];

    logic       r_wr_bank;
    logic       r_rd_bank;
    logic [2:0] r_row_cnt;
    logic [2:0] r_col_cnt;
    logic [1:0] r_full;
    logic [1:0] w_full_rel;
    logic [1:0] w_full_nxt;
    logic [2:0] r_col;
    logic       r_last;
    logic       r_overflow;
    logic       w_load;
    logic       w_release;
    logic       w_drop;
    logic       w_wr;

    assign w_in[0] = i_data0;
    assign w_in[1] = i_data1;
    assign w_in[2] = i_data2;
    assign w_in[3] = i_data3;
    assign w_in[4] = i_data4;
    assign w_in[5] = i_data5;
    assign w_in[6] = i_data6;
    assign w_in[7] = i_data7;

    assign o_valid    = (r_state == ST_STREAM);
    assign o_data0    = r_out[0];
    assign o_data1    = r_out[1];
    assign o_data2    = r_out[2];
    assign o_data3    = r_out[3];
    assign o_data4    = r_out[4];
    assign o_data5    = r_out[5];
    assign o_data6    = r_out[6];
    assign o_data7    = r_out[7];
    assign o_col      = r_col;
    assign o_last     = r_last;
    assign o_overflow = r_overflow;

    // Output register takes a new column whenever it is empty or being consumed.
    assign w_load    = (!o_valid || i_ready) && r_full[r_rd_bank];
    assign w_release = w_load && (r_col_cnt == 3'd7);

    // The bank whose last column is captured this edge is already free for
    // the drop check, so a new block may start on that same edge. The write
    // lands in memory after the read capture, so the old data is not disturbed.
    always_comb begin
        w_full_rel = r_full;
        if (w_release) begin
            w_full_rel[r_rd_bank] = 1'b0;
        end
    end

    // Only row 0 needs the check: a bank that accepted row 0 stays ours.
    assign w_drop = i_valid && (r_row_cnt == 3'd0) && w_full_rel[r_wr_bank];
    assign w_wr   = i_valid && !w_drop;

    always_comb begin
        w_full_nxt = w_full_rel;
        if (w_wr && (r_row_cnt == 3'd7)) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            for (int c = 0; c < 8; c++) begin
                r_mem[r_wr_bank][r_row_cnt][c] <= w_in[c];
            end
        end
    end

    // Write side bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_bank  <= 1'b0;
            r_row_cnt  <= 3'd0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_wr) begin
                r_row_cnt <= r_row_cnt + 3'd1;
                if (r_row_cnt == 3'd7) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
        end
    end

    // Read side: output register and column counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_bank <= 1'b0;
            r_col_cnt <= 3'd0;
            r_col     <= 3'd0;
            r_last    <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_out[k] <= '0;
            end
        end else if (w_load) begin
            for (int k = 0; k < 8; k++) begin
                r_out[k] <= r_mem[r_rd_bank][k][r_col_cnt];
            end
            r_col     <= r_col_cnt;
            r_last    <= (r_col_cnt == 3'd7);
            r_col_cnt <= r_col_cnt + 3'd1;
            if (r_col_cnt == 3'd7) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (i_ready && !w_load) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Sits between the row 1-D DCT and the column 1-D DCT of the 2-D 8x8 DCT pipeline.
- Collects 8 consecutive row-DCT result vectors (8 x signed coefficients) into an 8x8 block, then emits the block column by column so the column DCT sees transposed data.
- Ping-pong banked: one bank fills while the other drains; downstream back-pressure via i_ready.

Parameters:
- DATA_W, 14, signed width of each coefficient in and out.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  row vector present this cycle (no upstream stall; producer never waits)
- i_data0..i_data7  in  DATA_W each, signed  row coefficients, index = column position
- i_ready  in  1  downstream accepts o_data this cycle
- o_valid  out  1  column vector valid
- o_data0..o_data7  out  DATA_W each, signed  column coefficients, index = row position
- o_col  out  3  column index of current output (0..7)
- o_last  out  1  high with column 7 of a block
- o_overflow  out  1  sticky: a row was dropped

Behaviour:
- Storage: 2 banks x 8 rows x 8 x DATA_W. Data passes bit-exact, no arithmetic or rounding.
- Reset (async assert, sync deassert): o_valid=0, o_data*=0, o_col=0, o_last=0, o_overflow=0, wr_bank=0, rd_bank=0, row_cnt=0, col_cnt=0, full[1:0]=0. Bank contents are not reset.
- Reset mid-block discards all partial and full banks. The first i_valid after release is row 0.
- Write side: on i_valid, vector goes to bank wr_bank, row row_cnt, then row_cnt++.
  - When row_cnt==7 is written: full[wr_bank] set, wr_bank toggles, row_cnt wraps to 0.
  - Gaps in i_valid are allowed; row_cnt holds.
- Drop rule: if i_valid, row_cnt==0 and full[wr_bank]==1 after this edge's release (see same-edge rule), the row is dropped.
  - row_cnt does not advance and o_overflow is set; it stays set until reset.
  - Only row 0 is checked; once a bank is entered it is guaranteed free.
- Read side: output register loads when (!o_valid || i_ready) and full[rd_bank].
  - Load: o_data[k] = bank[rd_bank][row k][col_cnt], o_col=col_cnt, o_last=(col_cnt==7), o_valid=1, col_cnt++.
  - On loading col 7: full[rd_bank] cleared, rd_bank toggles, col_cnt=0.
  - Otherwise, if i_ready, o_valid goes to 0.
  - While o_valid && !i_ready, all outputs hold stable.
- Read states: IDLE (o_valid=0), STREAM (o_valid=1). IDLE->STREAM on load. STREAM->IDLE when i_ready and no load.
- Same-edge rule: a bank freed on the edge its col 7 is loaded may accept row 0 on that same edge. The write lands after the read capture, so no corruption. The freed flag is visible combinationally to the drop check.
- Latency: row 7 written at edge N gives column 0 on o_data after edge N+1 (i_ready high), and column 7 after edge N+8.
- Throughput: with i_ready held high, continuous 1 row/cycle input never overflows.

Test Plan:
- Single block: rows r=0..7 with i_data[c]=r*8+c, i_ready=1 -> 8 consecutive o_valid cycles starting 1 cycle after row 7. Column c gives o_data[k]=k*8+c, o_col=c, o_last only at c=7.
- Continuous 4 blocks, i_valid=1 every cycle, negative values -(b*64+r*8+c) -> 32 back-to-back output columns, all transposed correctly, o_overflow=0.
- Back-pressure: i_ready toggled 1,0,0,1 during streaming -> outputs frozen while low, no column skipped or duplicated, col sequence 0..7.
- Overflow: i_ready=0 throughout, feed 3 blocks -> blocks 0 and 1 stored. Block 2 row 0 is dropped, o_overflow=1 sticky, and rows 1..7 are dropped via row_cnt==0 re-checks. After i_ready=1, blocks 0 and 1 output intact.
- Same-edge release: hold i_ready so bank 0 col 7 loads on the same edge as row 0 of a new block -> row accepted, o_overflow=0, next block transposes correctly.
- Reset mid-operation: assert i_rst_n=0 after row 4 and while streaming col 3 -> outputs 0 immediately. After release a fresh full block transposes correctly with no stale columns emitted.
